// File: rtl/regfile_rd_seq_if.sv
// Output byte stream of the register-bank read sequencer (valid/ready).
// Optional macro REGFILE_RD_PARITY_EN adds the out_par sideband.
interface regfile_rd_seq_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef REGFILE_RD_PARITY_EN
    logic       out_par;

    modport master (output out_data, output out_valid, output out_par, input out_ready);
    modport slave  (input out_data, input out_valid, input out_par, output out_ready);
`else
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
`endif
endinterface

// File: rtl/regfile_rd_seq.sv
// Reads base_addr..base_addr+count-1 from the register bank into a 2-entry skid FIFO.
// Optional macro REGFILE_RD_PARITY_EN stores an even-parity bit per byte and drives out_par.
module regfile_rd_seq #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rstbar,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rf_raddr,
    output logic              rf_re,
    input  logic [7:0]        rf_rdata,
    regfile_rd_seq_if.master  out_if,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_e;

    localparam logic [ADDR_W-1:0] ONE_ADDR = 1;
    localparam logic [ADDR_W:0]   ONE_CNT  = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [1:0]        occ_q, occ_d;
    logic              head_q, head_d;
    logic [7:0]        mem_q [2];
`ifdef REGFILE_RD_PARITY_EN
    logic              par_q [2];
`endif

    logic pop;
    logic push;
    logic wr_idx;

    assign out_if.out_valid = (occ_q != 2'd0);
    assign out_if.out_data  = out_if.out_valid ? mem_q[head_q] : 8'h00;
`ifdef REGFILE_RD_PARITY_EN
    assign out_if.out_par   = out_if.out_valid ? par_q[head_q] : 1'b0;
`endif

    assign pop      = out_if.out_valid & out_if.out_ready;
    assign push     = rf_re;
    // Tail slot; with two entries held it aliases the head, which is being popped.
    assign wr_idx   = head_q ^ occ_q[0];
    assign rf_raddr = raddr_q;

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        remaining_d = remaining_q;
        occ_d       = occ_q;
        head_d      = head_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        rf_re       = (state_q == S_READ) && (remaining_q != '0) && ((occ_q != 2'd2) || pop);

        if (push) begin
            raddr_d     = raddr_q + ONE_ADDR;
            remaining_d = remaining_q - ONE_CNT;
        end
        occ_d = occ_q + 2'(push) - 2'(pop);
        if (pop) begin
            head_d = ~head_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    raddr_d     = base_addr;
                    remaining_d = count;
                    state_d     = (count != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (push && (remaining_q == ONE_CNT)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && (occ_q == 2'd1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything except an idle start request.
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            occ_d       = 2'd0;
            remaining_d = '0;
            head_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstbar) begin
        if (!rstbar) begin
            state_q     <= S_IDLE;
            raddr_q     <= '0;
            remaining_q <= '0;
            occ_q       <= 2'd0;
            head_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            raddr_q     <= raddr_d;
            remaining_q <= remaining_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
        end
    end

    // NOTE: payload storage is deliberately left without reset; every output is masked by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= rf_rdata;
`ifdef REGFILE_RD_PARITY_EN
            par_q[wr_idx] <= ^rf_rdata;
`endif
        end
    end

endmodule
